// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// division, one bit per cycle, with a registered result and a single-cycle done pulse.
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int FUNCT3_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [FUNCT3_LENGTH-1:0] funct3,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic                     flush,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    Result
);
    // state | meaning
    // IDLE  | waiting for start
    // PREP  | magnitudes, result sign, divide special cases
    // RUN   | one product/quotient bit per cycle
    // DONE  | done pulse, Result valid, back-to-back start accepted
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;

    state_t                   state;
    logic [FUNCT3_LENGTH-1:0] op;
    logic [DATA_WIDTH-1:0]    a_reg, b_reg, hi, lo;
    logic                     neg_res;
    logic [CW-1:0]            counter;

    logic                     is_div, signed_a, signed_b, a_neg, b_neg, neg_prep;
    logic                     div_zero, div_ovf;
    logic [DATA_WIDTH-1:0]    mag_a, mag_b, special_res;
    logic [DATA_WIDTH:0]      mul_sum, div_sh, div_diff;
    logic                     div_ge;
    logic [DATA_WIDTH-1:0]    hi_n, lo_n, q_s, r_s, fin;
    logic [2*DATA_WIDTH-1:0]  prod, prod_s;

    always_comb begin
        is_div   = op[2];
        signed_a = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        signed_b = is_div ? ~op[0] : (op[1:0] == 2'b01);
        a_neg    = signed_a & a_reg[DATA_WIDTH-1];
        b_neg    = signed_b & b_reg[DATA_WIDTH-1];
        mag_a    = a_neg ? -a_reg : a_reg;
        mag_b    = b_neg ? -b_reg : b_reg;
        // Remainder follows the dividend's sign; everything else is the XOR of signs.
        neg_prep = (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div && (b_reg == '0);
        div_ovf  = is_div && !op[0] && (a_reg == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                   && (b_reg == '1);
        if (div_zero)
            special_res = op[1] ? a_reg : '1;
        else
            special_res = op[1] ? '0 : a_reg;
    end

    // hi/lo are shared: {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, hi} + {1'b0, b_reg & {DATA_WIDTH{lo[0]}}};
        div_sh   = {hi, lo[DATA_WIDTH-1]};
        div_diff = div_sh - {1'b0, b_reg};
        div_ge   = (div_sh >= {1'b0, b_reg});
        if (is_div) begin
            hi_n = div_ge ? div_diff[DATA_WIDTH-1:0] : div_sh[DATA_WIDTH-1:0];
            lo_n = {lo[DATA_WIDTH-2:0], div_ge};
        end else begin
            hi_n = mul_sum[DATA_WIDTH:1];
            lo_n = {mul_sum[0], lo[DATA_WIDTH-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_s = neg_res ? -prod : prod;
        q_s    = neg_res ? -lo_n : lo_n;
        r_s    = neg_res ? -hi_n : hi_n;
        if (is_div)
            fin = op[1] ? r_s : q_s;
        else if (op[1:0] == 2'b00)
            fin = prod_s[DATA_WIDTH-1:0];
        else
            fin = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            hi      <= '0;
            lo      <= '0;
            neg_res <= 1'b0;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Result  <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            op    <= funct3;
                            a_reg <= SrcA;
                            b_reg <= SrcB;
                            busy  <= 1'b1;
                            state <= PREP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PREP: begin
                        if (div_zero || div_ovf) begin
                            Result <= special_res;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            hi      <= '0;
                            lo      <= mag_a;
                            b_reg   <= mag_b;
                            neg_res <= neg_prep;
                            counter <= CNT_INIT;
                            state   <= RUN;
                        end
                    end
                    RUN: begin
                        hi      <= hi_n;
                        lo      <= lo_n;
                        counter <= counter - CW'(1);
                        if (counter == CW'(1)) begin
                            Result <= fin;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: table of operations with hand-computed results
// and latencies, plus sequences for flush, reset, back-to-back and ignored starts.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.DATA_WIDTH(32), .FUNCT3_LENGTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .SrcA(src_a), .SrcB(src_b), .flush(flush),
        .busy(busy), .done(done), .Result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs[24];
    int   nv = 0;

    task automatic add(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit sp);
        vecs[nv].name = nm; vecs[nv].f = f; vecs[nv].a = a; vecs[nv].b = b;
        vecs[nv].exp = exp; vecs[nv].special = sp;
        nv++;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Waits up to 80 edges for done; returns edge count and whether busy/done behaved.
    task automatic wait_done(output int n, output bit ok);
        n = 0;
        ok = 1'b1;
        while (n < 80 && !done) begin
            @(posedge clk); #1;
            n++;
            if (done && busy) ok = 1'b0;
            if (!done && !busy) ok = 1'b0;
        end
    endtask

    task automatic run_op(input vec_t v);
        int n;
        bit ok;
        @(negedge clk);
        funct3 = v.f; src_a = v.a; src_b = v.b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        src_a = ~v.a;
        src_b = v.b ^ 32'h0000_0005;
        funct3 = ~v.f;
        check({v.name, " busy in PREP"}, {31'b0, busy & ~done}, 32'd1);
        wait_done(n, ok);
        check({v.name, " result"}, result, v.exp);
        check({v.name, " latency"}, n, v.special ? 32'd1 : 32'd33);
        check({v.name, " busy/done"}, {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        check({v.name, " single done"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int  n;
        bit  ok;
        bit  seen;

        add("MUL 7*-3",          3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        add("MUL 0*x",           3'b000, 32'd0,          32'h0000_0123, 32'h0000_0000, 0);
        add("MUL shift",         3'b000, 32'h1234_5678,  32'h0000_0010, 32'h2345_6780, 0);
        add("MULH min*min",      3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        add("MULHU min*min",     3'b011, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        add("MULHSU min*min",    3'b010, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, 0);
        add("MULH -1*-1",        3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 0);
        add("MULHU max*max",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        add("MULHSU -1*max",     3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        add("DIV -7/2",          3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        add("REM -7/2",          3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        add("DIVU 100/7",        3'b101, 32'd100,        32'd7,         32'd14,        0);
        add("REMU 100/7",        3'b111, 32'd100,        32'd7,         32'd2,         0);
        add("DIV 7/-2",          3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        add("REM 7/-2",          3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         0);
        add("REM -8/3",          3'b110, 32'hFFFF_FFF8,  32'd3,         32'hFFFF_FFFE, 0);
        add("DIV min/1",         3'b100, 32'h8000_0000,  32'd1,         32'h8000_0000, 0);
        add("DIVU max/1",        3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 0);
        add("DIV 5/0",           3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        add("REM 5/0",           3'b110, 32'd5,          32'd0,         32'd5,         1);
        add("DIVU 5/0",          3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        add("REMU x/0",          3'b111, 32'h0000_1234,  32'd0,         32'h0000_1234, 1);
        add("DIV ovf",           3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        add("REM ovf",           3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);

        #12;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset Result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++) run_op(vecs[i]);

        // Flush in RUN cycle 10 after a known result of 30.
        run_op('{"MUL 5*6", 3'b000, 32'd5, 32'd6, 32'd30, 1'b0});
        @(negedge clk);
        funct3 = 3'b011; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        check("flush done", {31'b0, done}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("flush quiet", {31'b0, seen}, 32'd0);
        check("flush Result held", result, 32'd30);

        // Simultaneous start and flush in IDLE.
        @(negedge clk);
        funct3 = 3'b000; src_a = 32'd2; src_b = 32'd2; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("start+flush busy", {31'b0, busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("start+flush quiet", {31'b0, seen}, 32'd0);
        check("start+flush Result", result, 32'd30);

        // Reset in the middle of RUN.
        @(negedge clk);
        funct3 = 3'b101; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrun reset busy", {31'b0, busy}, 32'd0);
        check("midrun reset done", {31'b0, done}, 32'd0);
        check("midrun reset Result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op('{"DIVU 1000/3 after reset", 3'b101, 32'd1000, 32'd3, 32'd333, 1'b0});

        // Back-to-back: start held through DONE.
        @(negedge clk);
        funct3 = 3'b000; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        wait_done(n, ok);
        check("b2b first latency", n, 32'd33);
        check("b2b first Result", result, 32'd12);
        funct3 = 3'b101; src_a = 32'd9; src_b = 32'd3;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) start = 1'b0;
        end while (n < 80 && !done);
        check("b2b done spacing", n, 32'd34);
        check("b2b second Result", result, 32'd3);

        // start pulsed while busy is ignored.
        @(negedge clk);
        funct3 = 3'b000; src_a = 32'd5; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 funct3 = 3'b101; src_a = 32'd100; src_b = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n, ok);
        check("busy-start latency", n, 32'd27);
        check("busy-start Result", result, 32'd35);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("busy-start no rerun", {31'b0, seen}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
